// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the miner controllers: register map of the external
// sha256 core, CTRL/STATUS bit positions, mode encodings and the sweep
// controller state encoding.
// -----------------------------------------------------------------------------
package miner_pkg;

    // sha256 core register map
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

    // CTRL register bits
    localparam int CTRL_INIT_BIT = 0;
    localparam int CTRL_NEXT_BIT = 1;
    localparam int CTRL_MODE_BIT = 2;

    // STATUS register bits
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_VALID_BIT = 1;

    // Digest modes (value of the CTRL mode bit)
    localparam logic MODE_SHA_224 = 1'b0;
    localparam logic MODE_SHA_256 = 1'b1;

    localparam int BLOCK_WORDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WR_NONCE,
        ST_WR_CTRL,
        ST_SETTLE,
        ST_POLL,
        ST_READ_DIG,
        ST_DONE
    } state_t;

    // Index of the last digest word for a given mode.
    function automatic logic [2:0] last_digest_idx(input logic mode);
        return (mode == MODE_SHA_256) ? 3'd7 : 3'd6;
    endfunction

endpackage

// File: rtl/digest_zero_check.sv
// -----------------------------------------------------------------------------
// digest_zero_check
// Checks one digest word against the number of leading zero bits still
// required. Purely combinational.
//   word     : digest word, MSB first in the digest
//   rem      : leading zero bits still required before this word
//   pass     : word satisfies its share of the requirement
//   rem_next : requirement left for the following word (saturates at 0)
// -----------------------------------------------------------------------------
module digest_zero_check #(
    parameter int BITS = 32,
    parameter int ZW   = 9
) (
    input  logic [BITS-1:0] word,
    input  logic [ZW-1:0]   rem,
    output logic            pass,
    output logic [ZW-1:0]   rem_next
);

    localparam logic [ZW-1:0] WORD_BITS = ZW'(BITS);

    logic [BITS-1:0] mask;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can leave a latch behind.
        mask     = '1;
        rem_next = '0;
        if (rem >= WORD_BITS) begin
            rem_next = rem - WORD_BITS;
        end else begin
            // Top 'rem' bits set; rem==0 gives an empty mask (always passes).
            mask = ~({BITS{1'b1}} >> rem);
        end
        pass = ((word & mask) == '0);
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nonce_sweep_ctrl
// Loads a 512-bit block header into the sha256 core over the host valid/ready
// path, then sweeps an inclusive nonce range: for each nonce it rewrites the
// nonce word, starts a hash and checks the digest for leading zeros.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : level, sampled in IDLE; dropping it leaves DONE
//   abort             : stop the sweep, go to DONE with no result flags
//   ctrl_bits[2:0]    : {mode, next, init} written to the core CTRL register
//   nonce_start/end   : inclusive range (wraps through all-ones to zero)
//   zero_bits         : required leading zero bits of the digest
//   valid, wb_wr_mask, wdata : host transfer; ready acks, rdata returns data
//   sha_*             : register interface of the sha256 core
//   idle, busy, found, exhausted, nonce_out : status
// -----------------------------------------------------------------------------
module nonce_sweep_ctrl
    import miner_pkg::*;
#(
    parameter int         BITS       = 32,
    parameter logic [7:0] NONCE_ADDR = 8'h13,
    parameter int         ZW         = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      ctrl_bits,
    input  logic [BITS-1:0] nonce_start,
    input  logic [BITS-1:0] nonce_end,
    input  logic [ZW-1:0]   zero_bits,
    input  logic            valid,
    input  logic [3:0]      wb_wr_mask,
    input  logic [BITS-1:0] wdata,
    output logic            ready,
    output logic [BITS-1:0] rdata,
    output logic            sha_cs,
    output logic            sha_we,
    output logic [7:0]      sha_address,
    output logic [BITS-1:0] sha_write_data,
    input  logic [BITS-1:0] sha_read_data,
    output logic            idle,
    output logic            busy,
    output logic            found,
    output logic            exhausted,
    output logic [BITS-1:0] nonce_out
);

    localparam logic [ZW-1:0] ZB_256 = ZW'(256);
    localparam logic [ZW-1:0] ZB_224 = ZW'(224);

    state_t          state_q, state_d;
    logic [BITS-1:0] cur_q;
    logic [BITS-1:0] end_q;
    logic [ZW-1:0]   zb_q;
    logic [ZW-1:0]   rem_q;
    logic [2:0]      ctrl_q;
    logic [3:0]      load_cnt_q;
    logic [2:0]      widx_q;
    logic [2:0]      rd_idx_q;
    logic            settle_q;

    logic            host_acc;
    logic            go_found;
    logic            go_exh;
    logic            go_next;
    logic            zc_pass;
    logic [ZW-1:0]   zc_rem_next;
    logic [2:0]      last_idx;
    logic [ZW-1:0]   zb_clamped;

    assign last_idx = last_digest_idx(ctrl_q[CTRL_MODE_BIT]);

    // Requirement beyond the digest width is meaningless; clamp it.
    always_comb begin
        zb_clamped = zero_bits;
        if (ctrl_bits[CTRL_MODE_BIT] == MODE_SHA_256) begin
            if (zero_bits > ZB_256) zb_clamped = ZB_256;
        end else begin
            if (zero_bits > ZB_224) zb_clamped = ZB_224;
        end
    end

    digest_zero_check #(
        .BITS(BITS),
        .ZW  (ZW)
    ) u_zero_check (
        .word    (sha_read_data),
        .rem     (rem_q),
        .pass    (zc_pass),
        .rem_next(zc_rem_next)
    );

    assign idle = (state_q == ST_IDLE);
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // Next state, core bus and decision strobes.
    always_comb begin
        state_d        = state_q;
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = '0;
        sha_write_data = '0;
        host_acc       = 1'b0;
        go_found       = 1'b0;
        go_exh         = 1'b0;
        go_next        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only touch the core while a sweep is requested.
                if (start) begin
                    sha_cs      = 1'b1;
                    sha_address = ADDR_STATUS;
                    if (sha_read_data[STATUS_READY_BIT]) state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (valid && !ready) begin
                    host_acc = 1'b1;
                    if (wb_wr_mask == 4'b1111) begin
                        sha_cs         = 1'b1;
                        sha_we         = 1'b1;
                        sha_address    = ADDR_BLOCK0 + 8'(load_cnt_q);
                        sha_write_data = wdata;
                        if (load_cnt_q == 4'(BLOCK_WORDS - 1)) state_d = ST_WR_NONCE;
                    end
                end
            end
            ST_WR_NONCE: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = NONCE_ADDR;
                sha_write_data = cur_q;
                state_d        = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_CTRL;
                sha_write_data = BITS'(ctrl_q);
                state_d        = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Status is stale right after init; wait two cycles.
                if (settle_q) state_d = ST_POLL;
            end
            ST_POLL: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_STATUS;
                if (sha_read_data[STATUS_VALID_BIT]) state_d = ST_READ_DIG;
            end
            ST_READ_DIG: begin
                sha_cs      = 1'b1;
                sha_address = ADDR_DIGEST0 + 8'(widx_q);
                if (!zc_pass) begin
                    if (cur_q == end_q) begin
                        go_exh  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        go_next = 1'b1;
                        state_d = ST_WR_NONCE;
                    end
                end else if ((widx_q == last_idx) || (zc_rem_next == '0)) begin
                    go_found = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (valid && !ready) begin
                    host_acc = 1'b1;
                    if (wb_wr_mask == 4'b0000) begin
                        sha_cs      = 1'b1;
                        sha_address = ADDR_DIGEST0 + 8'(rd_idx_q);
                    end
                end
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort stops the sweep, but a found decision in the same cycle wins.
        if (abort && busy && !go_found) begin
            state_d = ST_DONE;
            go_exh  = 1'b0;
            go_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            end_q      <= '0;
            zb_q       <= '0;
            rem_q      <= '0;
            ctrl_q     <= '0;
            load_cnt_q <= '0;
            widx_q     <= '0;
            rd_idx_q   <= '0;
            settle_q   <= 1'b0;
            ready      <= 1'b0;
            rdata      <= '0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            nonce_out  <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q  <= state_d;
            ready    <= host_acc;
            // High on the second SETTLE cycle only.
            settle_q <= (state_q == ST_SETTLE);

            if (state_q == ST_IDLE && state_d == ST_LOAD) begin
                cur_q      <= nonce_start;
                end_q      <= nonce_end;
                zb_q       <= zb_clamped;
                ctrl_q     <= ctrl_bits;
                load_cnt_q <= '0;
                found      <= 1'b0;
                exhausted  <= 1'b0;
            end

            if (state_q == ST_LOAD && host_acc && wb_wr_mask == 4'b1111) begin
                load_cnt_q <= load_cnt_q + 4'd1;
            end

            if (state_q == ST_POLL && state_d == ST_READ_DIG) begin
                widx_q <= '0;
                rem_q  <= zb_q;
            end

            if (state_q == ST_READ_DIG && state_d == ST_READ_DIG) begin
                widx_q <= widx_q + 3'd1;
                rem_q  <= zc_rem_next;
            end

            if (go_next) cur_q <= cur_q + 1'b1;

            if (state_d == ST_DONE && state_q != ST_DONE) begin
                found     <= go_found;
                exhausted <= go_exh;
                nonce_out <= cur_q;
                rd_idx_q  <= '0;
            end

            if (state_q == ST_DONE && host_acc && wb_wr_mask == 4'b0000) begin
                rdata    <= sha_read_data;
                rd_idx_q <= (rd_idx_q == last_idx) ? 3'd0 : rd_idx_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nonce_sweep_ctrl
// Drives nonce_sweep_ctrl against a small behavioural model of the sha256
// register interface whose digest is a fixed function of the nonce word.
// -----------------------------------------------------------------------------
module tb_nonce_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  ctrl_bits;
    logic [31:0] nonce_start;
    logic [31:0] nonce_end;
    logic [8:0]  zero_bits;
    logic        valid;
    logic [3:0]  wb_wr_mask;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        sha_cs;
    logic        sha_we;
    logic [7:0]  sha_address;
    logic [31:0] sha_write_data;
    logic [31:0] sha_read_data;
    logic        idle;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [31:0] nonce_out;

    always #5 clk = ~clk;

    nonce_sweep_ctrl #(.BITS(32), .NONCE_ADDR(8'h13), .ZW(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .ctrl_bits     (ctrl_bits),
        .nonce_start   (nonce_start),
        .nonce_end     (nonce_end),
        .zero_bits     (zero_bits),
        .valid         (valid),
        .wb_wr_mask    (wb_wr_mask),
        .wdata         (wdata),
        .ready         (ready),
        .rdata         (rdata),
        .sha_cs        (sha_cs),
        .sha_we        (sha_we),
        .sha_address   (sha_address),
        .sha_write_data(sha_write_data),
        .sha_read_data (sha_read_data),
        .idle          (idle),
        .busy          (busy),
        .found         (found),
        .exhausted     (exhausted),
        .nonce_out     (nonce_out)
    );

    // ---------------- sha256 core model ----------------
    logic [31:0] hdr [16];
    logic [31:0] blk [16];
    logic        core_ready;
    logic        core_valid;
    int          busy_cnt;
    int          hash_cnt = 0;
    logic [31:0] hashed [$];

    // Reference digest: nonce 7 with the known header has 8 leading zeros,
    // nonce 12 has 42, nonce 0x55 is all zero, nonce 0x66 has 224.
    function automatic logic [31:0] dig(input int i, input logic [31:0] n, input logic [31:0] h0);
        if (n == 32'd7 && h0 == hdr[0]) return (i == 0) ? 32'h00AB_CDEF : 32'hA5A5_0000 + 32'(i);
        if (n == 32'd12) return (i == 0) ? 32'h0 : (i == 1) ? 32'h003F_FFFF : 32'h0BAD_0000 + 32'(i);
        if (n == 32'h55) return 32'h0;
        if (n == 32'h66) return (i == 7) ? 32'hFFFF_FFFF : 32'h0;
        return (i == 0) ? (32'hF000_0000 ^ {16'h0, n[15:0]}) : 32'h1234_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            core_ready <= 1'b1;
            core_valid <= 1'b0;
            busy_cnt   <= 0;
        end else begin
            if (busy_cnt == 1) begin
                core_ready <= 1'b1;
                core_valid <= 1'b1;
            end
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (sha_cs && sha_we) begin
                if (sha_address[7:4] == 4'h1) blk[sha_address[3:0]] <= sha_write_data;
                if (sha_address == 8'h08 && sha_write_data[0]) begin
                    core_ready <= 1'b0;
                    core_valid <= 1'b0;
                    busy_cnt   <= 6;
                    hash_cnt   <= hash_cnt + 1;
                    hashed.push_back(blk[3]);
                end
            end
        end
    end

    always_comb begin
        sha_read_data = '0;
        if (sha_cs && !sha_we) begin
            if (sha_address == 8'h09)
                sha_read_data = {30'b0, core_valid, core_ready};
            else if (sha_address[7:4] == 4'h1)
                sha_read_data = blk[sha_address[3:0]];
            else if (sha_address >= 8'h20 && sha_address <= 8'h27)
                sha_read_data = dig(int'(sha_address[2:0]), blk[3], blk[0]);
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;
    int base_hash;
    int base_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] d, input logic [3:0] m, output logic [31:0] rd, output bit to);
        valid      = 1'b1;
        wdata      = d;
        wb_wr_mask = m;
        to         = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ready) begin
                to = 1'b0;
                break;
            end
        end
        rd         = rdata;
        valid      = 1'b0;
        wdata      = '0;
        wb_wr_mask = '0;
        @(negedge clk);
    endtask

    task automatic start_sweep(input logic [31:0] ns, input logic [31:0] ne,
                               input logic [8:0] zb, input logic [2:0] cb, input bit junk);
        int          n    = 0;
        int          acks = 0;
        int          tos  = 0;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] rd;
        bit          to;
        nonce_start = ns;
        nonce_end   = ne;
        zero_bits   = zb;
        ctrl_bits   = cb;
        base_hash   = hash_cnt;
        base_q      = hashed.size();
        start       = 1'b1;
        for (int t = 0; t < (junk ? 17 : 16); t++) begin
            if (junk && t == 2) begin
                d = 32'hDEAD_BEEF;
                m = 4'b0011;
            end else begin
                d = hdr[n];
                m = 4'b1111;
                n++;
            end
            if (junk && t == 16) begin
                repeat (6) @(negedge clk);
                check("no_hash_before_17th_xfer", 64'(hash_cnt - base_hash), 64'd0);
            end
            xfer(d, m, rd, to);
            if (to) tos++;
            else acks++;
        end
        check("load_xfer_timeouts", 64'(tos), 64'd0);
        if (junk) check("load_acks", 64'(acks), 64'd17);
    endtask

    task automatic wait_done(input string name);
        bit to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!idle && !busy) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_wait"}, 64'(to), 64'd0);
    endtask

    task automatic end_sweep();
        bit to = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (idle) begin
                to = 1'b0;
                break;
            end
        end
        check("idle_after_start_low", 64'(to), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] ns;
        logic [31:0] ne;
        logic [8:0]  zb;
        logic [2:0]  cb;
        logic        ef;
        logic        ee;
        logic [31:0] en;
        int          eh;
        int          rd_n;
    } vec_t;

    vec_t vt [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          to;
        int          words;
        int          errs;
        logic [63:0] got;
        logic [31:0] wrap_exp [4];

        for (int i = 0; i < 16; i++) hdr[i] = 32'h6A09_E667 ^ (32'(i) * 32'h0100_0193);

        //         name        ns            ne            zb   cb      ef    ee    en         eh rd
        vt[0] = '{"zb0",      32'd5,        32'd9,        9'd0,   3'b101, 1'b1, 1'b0, 32'd5,    1, 0};
        vt[1] = '{"single",   32'd5,        32'd5,        9'd256, 3'b101, 1'b0, 1'b1, 32'd5,    1, 0};
        vt[2] = '{"known7",   32'd0,        32'd20,       9'd8,   3'b101, 1'b1, 1'b0, 32'd7,    8, 10};
        vt[3] = '{"zb40",     32'd8,        32'd20,       9'd40,  3'b101, 1'b1, 1'b0, 32'd12,   5, 0};
        vt[4] = '{"zb43",     32'd8,        32'd14,       9'd43,  3'b101, 1'b0, 1'b1, 32'd14,   7, 0};
        vt[5] = '{"sha224",   32'h60,       32'h66,       9'd224, 3'b001, 1'b1, 1'b0, 32'h66,   7, 0};
        vt[6] = '{"sha256",   32'h60,       32'h66,       9'd256, 3'b101, 1'b0, 1'b1, 32'h66,   7, 0};
        vt[7] = '{"clamp",    32'h55,       32'h55,       9'd300, 3'b101, 1'b1, 1'b0, 32'h55,   1, 0};
        vt[8] = '{"rd224",    32'd8,        32'd20,       9'd40,  3'b001, 1'b1, 1'b0, 32'd12,   5, 9};

        rst = 1'b1; start = 1'b0; abort = 1'b0; ctrl_bits = '0;
        nonce_start = '0; nonce_end = '0; zero_bits = '0;
        valid = 1'b0; wb_wr_mask = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_found", 64'(found), 64'd0);
        check("rst_exhausted", 64'(exhausted), 64'd0);
        check("rst_nonce_out", 64'(nonce_out), 64'd0);
        check("rst_sha_cs", 64'(sha_cs), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven sweeps.
        for (int v = 0; v < 9; v++) begin
            start_sweep(vt[v].ns, vt[v].ne, vt[v].zb, vt[v].cb, 1'b0);
            wait_done(vt[v].name);
            check({vt[v].name, "_found"}, 64'(found), 64'(vt[v].ef));
            check({vt[v].name, "_exhausted"}, 64'(exhausted), 64'(vt[v].ee));
            check({vt[v].name, "_nonce_out"}, 64'(nonce_out), 64'(vt[v].en));
            check({vt[v].name, "_hashes"}, 64'(hash_cnt - base_hash), 64'(vt[v].eh));
            got = (hashed.size() > base_q) ? {32'h0, hashed[hashed.size()-1]} : '1;
            check({vt[v].name, "_last_hashed"}, got, 64'(vt[v].en));
            words = vt[v].cb[2] ? 8 : 7;
            for (int i = 0; i < vt[v].rd_n; i++) begin
                xfer(32'h0, 4'b0000, rd, to);
                check({vt[v].name, "_read_to"}, 64'(to), 64'd0);
                check({vt[v].name, "_read"}, 64'(rd), 64'(dig(i % words, vt[v].en, hdr[0])));
            end
            end_sweep();
        end

        // Wrap through all-ones to zero.
        wrap_exp[0] = 32'hFFFF_FFFE; wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0;         wrap_exp[3] = 32'h1;
        start_sweep(32'hFFFF_FFFE, 32'h1, 9'd256, 3'b101, 1'b0);
        wait_done("wrap");
        check("wrap_exhausted", 64'(exhausted), 64'd1);
        check("wrap_nonce_out", 64'(nonce_out), 64'd1);
        check("wrap_hashes", 64'(hash_cnt - base_hash), 64'd4);
        for (int k = 0; k < 4; k++) begin
            got = (hashed.size() > base_q + k) ? {32'h0, hashed[base_q + k]} : '1;
            check("wrap_order", got, 64'(wrap_exp[k]));
        end
        end_sweep();

        // Partial-mask transfer during LOAD is acked but not counted.
        start_sweep(32'd7, 32'd7, 9'd8, 3'b101, 1'b1);
        wait_done("mask");
        check("mask_found", 64'(found), 64'd1);
        check("mask_nonce_out", 64'(nonce_out), 64'd7);
        errs = 0;
        for (int i = 0; i < 16; i++) if (i != 3 && blk[i] !== hdr[i]) errs++;
        check("mask_block_contents", 64'(errs), 64'd0);
        end_sweep();

        // Reset in the middle of digest reading.
        start_sweep(32'd5, 32'd9, 9'd256, 3'b101, 1'b0);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy && sha_cs && !sha_we && sha_address == 8'h20) begin
                to = 1'b0;
                break;
            end
        end
        check("rst_mid_reach_read_dig", 64'(to), 64'd0);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", 64'(idle), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_found_exh", 64'({found, exhausted}), 64'd0);
        check("rst_mid_nonce_out", 64'(nonce_out), 64'd0);
        check("rst_mid_rdata", 64'(rdata), 64'd0);
        check("rst_mid_sha_bus", 64'({sha_cs, sha_we, sha_address, sha_write_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Abort while polling status.
        start_sweep(32'd0, 32'd20, 9'd256, 3'b101, 1'b0);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy && sha_cs && !sha_we && sha_address == 8'h09) begin
                to = 1'b0;
                break;
            end
        end
        check("abort_reach_poll", 64'(to), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done", 64'({idle, busy}), 64'd0);
        check("abort_found", 64'(found), 64'd0);
        check("abort_exhausted", 64'(exhausted), 64'd0);
        check("abort_nonce_out", 64'(nonce_out), 64'd0);
        end_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nonce_sweep_ctrl.md
# nonce_sweep_ctrl

Parametrised successor to the single-shot SHA controller. Loads a 512-bit block header over the Wishbone-derived valid/ready write path, then autonomously sweeps a nonce range. For each nonce it rewrites the nonce word in the SHA core, starts a hash, and checks the digest against a leading-zero target. Sits between `btc_miner_top` and the external `sha256` register interface, replacing the manual/auto LA sequencing.

## Interface
- `BITS`, 32: data/nonce word width.
- `NONCE_ADDR`, 8'h13: SHA block-word address overwritten with the nonce.
- `ZW`, 9: width of `zero_bits` (targets 0..256).
- `clk` in 1: single clock. `rst` in 1: reset, **synchronous, active-high**.
- `start` in 1: level; sampled in IDLE.
- `abort` in 1: stop sweep.
- `ctrl_bits` in 3: {mode, next, init} written to ADDR_CTRL; mode=1 means SHA-256.
- `nonce_start`, `nonce_end` in BITS: inclusive range, latched on start.
- `zero_bits` in ZW: required leading zero bits of the digest, latched on start.
- `valid` in 1, `wb_wr_mask` in 4, `wdata` in BITS: host transfer.
- `ready` out 1: one-cycle ack. `rdata` out BITS: read data.
- `sha_cs`, `sha_we` out 1; `sha_address` out 8; `sha_write_data` out BITS; `sha_read_data` in BITS (combinational read, same cycle).
- `idle`, `busy`, `found`, `exhausted` out 1; `nonce_out` out BITS: last nonce tried, or the winning nonce.

## Operation
- States: IDLE, LOAD, WR_NONCE, WR_CTRL, SETTLE, POLL, READ_DIG, DONE.
- IDLE: poll ADDR_STATUS. Go to LOAD when start=1 and ready bit=1. Latch range, target and ctrl_bits. Clear found/exhausted.
- LOAD: each valid&&!ready with mask 4'b1111 writes wdata to ADDR_BLOCK0+i, i=0..15. Other masks are acked but neither written nor counted. After word 15, go to WR_NONCE with cur=nonce_start.
- WR_NONCE: write cur to NONCE_ADDR. WR_CTRL: write ctrl_bits to ADDR_CTRL. SETTLE: 2 cycles with status ignored.
- POLL: read ADDR_STATUS until valid bit=1, then READ_DIG from ADDR_DIGEST0.
- READ_DIG: one word per cycle, MSB word first. `rem` starts at zero_bits. A word passes if rem≥32 and word==0, or if rem<32 and word[31:32-rem]==0. rem saturates at 0.
  - On the first failing word, stop reading.
  - If all words pass (8 words for SHA-256, 7 for SHA-224, or earlier once rem=0): found=1, go to DONE.
- Fail: if cur==nonce_end, exhausted=1 and go to DONE. Otherwise cur=cur+1 mod 2^BITS and go to WR_NONCE. The block is not reloaded.
- Wrap: nonce_start>nonce_end sweeps through all-ones to 0. start==end tries exactly one nonce.
- DONE: nonce_out = winning/last nonce.
  - A host read (valid, mask 0) returns core digest words from ADDR_DIGEST0 upward, wrapping after the last word for the mode.
  - start=0 returns to IDLE.
- abort=1 in any non-IDLE state: go to DONE next cycle with found=exhausted=0. An abort in the same cycle as a found decision loses to found.
- zero_bits>digest width is clamped to the digest width.

## Timing
- Reset values: all outputs 0, except idle=1. State=IDLE, cur=0.
- ready pulses exactly one cycle per accepted transfer and is never asserted twice back-to-back for one valid.
- Latency for a pass nonce: WR_NONCE 1 + WR_CTRL 1 + SETTLE 2 + core compute + POLL detect 1 + up to 8 digest cycles.
- found/exhausted/nonce_out update in the cycle DONE is entered.
- Reset mid-operation: IDLE next edge; the core is reset via the same rst.

## Structure
- `miner_pkg`: SHA register address constants, CTRL/STATUS bit indices, MODE_SHA_224/256, and the state encoding. The existing controller imports the same package.
- Sub-module `digest_zero_check`: word, rem → pass, rem_next. Purely combinational.
- The `sha256` instance stays in the top-level wrapper.

## Test plan
- zero_bits=0, range 5..9 → found after first digest word, nonce_out=5.
- zero_bits=256, range 5..5 → exactly 1 hash, exhausted=1, nonce_out=5.
- zero_bits=256, range FFFFFFFE..00000001 → 4 hashes in order FFFFFFFE, FFFFFFFF, 0, 1; exhausted, nonce_out=1.
- Known header with nonce 7 giving ≥8 leading zeros; zero_bits=8, range 0..20 → found, nonce_out=7. DONE reads return the reference digest, then wrap.
- LOAD with mask 4'b0011 on third transfer → acked, not counted; 17 total transfers needed.
- Abort during POLL → DONE with found=exhausted=0. rst mid-READ_DIG → all outputs at reset values next cycle.
